race_controller: RTL and testbench

Top-level game-flow controller for the racing game, generalising the single-car start/crash/finish sequencer to NUM_CARS cars with lap counting, a 3-2-1 start countdown, timed crash penalties and a user pause. It sits between the PS/2 key decoder, the pixel-level overlap signals from the renderer, and the car/road motion blocks. It gates motion via `pause`/`car_freeze` and selects on-screen overlays.

---
 rtl/race_controller_if.sv | 49 ++++
 rtl/race_controller.sv | 227 ++++++++++++++++++++++
 tb/tb_race_controller.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/race_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : race_controller_if
// Description : Bundles the key, renderer-overlap and motion/overlay signals
//               exchanged with race_controller. The slave modport is the
//               controller; the master modport is whatever drives it.
// Revision    : 1.0 - initial release
// ============================================================================
interface race_controller_if #(
    parameter int NUM_CARS = 2,
    parameter int LAPS     = 3
) ();
    localparam int LW = $clog2(LAPS + 1);

    // Inputs to the controller
    logic                     frame_tick;
    logic                     video_on;
    logic                     road_on;
    logic                     finish_line;
    logic [NUM_CARS-1:0]      car_on;
    logic                     enter_key;
    logic                     pause_key;

    // Outputs from the controller
    logic                     start_en;
    logic                     countdown_en;
    logic [1:0]               countdown_digit;
    logic                     pause;
    logic                     game_reset;
    logic [NUM_CARS-1:0]      car_freeze;
    logic                     finish_en;
    logic [1:0]               winner;
    logic [NUM_CARS*LW-1:0]   lap_count;

    modport master (
        output frame_tick, video_on, road_on, finish_line, car_on,
               enter_key, pause_key,
        input  start_en, countdown_en, countdown_digit, pause, game_reset,
               car_freeze, finish_en, winner, lap_count
    );

    modport slave (
        input  frame_tick, video_on, road_on, finish_line, car_on,
               enter_key, pause_key,
        output start_en, countdown_en, countdown_digit, pause, game_reset,
               car_freeze, finish_en, winner, lap_count
    );
endinterface
`default_nettype wire

// File: rtl/race_controller.sv
`default_nettype none
// ============================================================================
// Module      : race_controller
// Description : Game-flow sequencer for a NUM_CARS race: start page, 3-2-1
//               countdown, race with lap counting and crash penalties, user
//               pause/abort, and finish page with latched winner.
// Revision    : 1.0 - initial release
// ============================================================================
module race_controller #(
    parameter int NUM_CARS          = 2,
    parameter int LAPS              = 3,
    parameter int COUNTDOWN_FRAMES  = 60,
    parameter int CRASH_HOLD_FRAMES = 90
) (
    input  wire logic clk,
    input  wire logic reset,
    race_controller_if.slave bus
);
    localparam int LW = $clog2(LAPS + 1);
    localparam int HW = $clog2(CRASH_HOLD_FRAMES + 1);
    localparam int CW = $clog2(COUNTDOWN_FRAMES + 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_COUNTDOWN = 3'd1;
    localparam logic [2:0] c_RACE      = 3'd2;
    localparam logic [2:0] c_PAUSED    = 3'd3;
    localparam logic [2:0] c_OVER      = 3'd4;

    localparam logic [LW-1:0] c_LAPS    = LW'(LAPS);
    localparam logic [HW-1:0] c_HOLD    = HW'(CRASH_HOLD_FRAMES);
    localparam logic [CW-1:0] c_CD_LAST = CW'(COUNTDOWN_FRAMES - 1);

    logic [2:0]    state_q, state_d;
    logic          enter_q, enter_d;
    logic          pause_q, pause_d;
    logic [1:0]    digit_q, digit_d;
    logic [CW-1:0] cd_cnt_q, cd_cnt_d;
    logic [1:0]    winner_q, winner_d;

    logic                   w_enter_rise;
    logic                   w_pause_rise;
    logic                   w_to_idle;
    logic                   w_win_any;
    logic [1:0]             w_win_idx;
    logic [NUM_CARS-1:0]    w_lap_full;
    logic [NUM_CARS-1:0]    w_freeze;
    logic [NUM_CARS*LW-1:0] w_lap_count;

    assign w_enter_rise = bus.enter_key & ~enter_q;
    assign w_pause_rise = bus.pause_key & ~pause_q;

    // Lowest-index car at the lap target wins ties on the same tick
    always_comb begin
        w_win_any = 1'b0;
        w_win_idx = 2'd0;
        for (int i = NUM_CARS - 1; i >= 0; i--) begin
            if (w_lap_full[i]) begin
                w_win_any = 1'b1;
                w_win_idx = 2'(i);
            end
        end
    end

    // Next-state, countdown sequencing and winner latch
    always_comb begin
        enter_d  = bus.enter_key;
        pause_d  = bus.pause_key;
        state_d  = state_q;
        digit_d  = digit_q;
        cd_cnt_d = cd_cnt_q;
        winner_d = winner_q;
        case (state_q)
            c_IDLE: begin
                if (w_enter_rise) begin
                    state_d  = c_COUNTDOWN;
                    digit_d  = 2'd3;
                    cd_cnt_d = '0;
                end
            end
            c_COUNTDOWN: begin
                if (bus.frame_tick) begin
                    if (cd_cnt_q == c_CD_LAST) begin
                        cd_cnt_d = '0;
                        if (digit_q == 2'd1) begin
                            state_d = c_RACE;
                            digit_d = 2'd0;
                        end else begin
                            digit_d = digit_q - 2'd1;
                        end
                    end else begin
                        cd_cnt_d = cd_cnt_q + 1'b1;
                    end
                end
            end
            c_RACE: begin
                // A finished race outranks a simultaneous pause request
                if (w_win_any) begin
                    state_d  = c_OVER;
                    winner_d = w_win_idx;
                end else if (w_pause_rise) begin
                    state_d = c_PAUSED;
                end
            end
            c_PAUSED: begin
                if (w_enter_rise) begin
                    state_d = c_IDLE;
                end else if (w_pause_rise) begin
                    state_d = c_RACE;
                end
            end
            c_OVER: begin
                if (w_enter_rise) begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
        if (state_d == c_IDLE) begin
            digit_d  = 2'd0;
            cd_cnt_d = '0;
            winner_d = 2'd0;
        end
    end

    // Going to (or staying in) IDLE wipes all per-race bookkeeping
    assign w_to_idle = (state_d == c_IDLE);

    // Global state registers; key history resets high so a held key is ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= c_IDLE;
            enter_q  <= 1'b1;
            pause_q  <= 1'b1;
            digit_q  <= 2'd0;
            cd_cnt_q <= '0;
            winner_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            enter_q  <= enter_d;
            pause_q  <= pause_d;
            digit_q  <= digit_d;
            cd_cnt_q <= cd_cnt_d;
            winner_q <= winner_d;
        end
    end

    for (genvar i = 0; i < NUM_CARS; i++) begin : g_car
        logic          off_hit_q, off_hit_d;
        logic          fin_hit_q, fin_hit_d;
        logic          fin_prev_q, fin_prev_d;
        logic [LW-1:0] lap_q, lap_d;
        logic [HW-1:0] hold_q, hold_d;
        logic          w_off_pix;
        logic          w_fin_pix;

        assign w_off_pix = bus.video_on & bus.car_on[i] & ~bus.road_on;
        assign w_fin_pix = bus.video_on & bus.car_on[i] & bus.finish_line;

        // Per-frame hit accumulation plus crash-hold and lap update at frame end
        always_comb begin
            off_hit_d  = off_hit_q;
            fin_hit_d  = fin_hit_q;
            fin_prev_d = fin_prev_q;
            lap_d      = lap_q;
            hold_d     = hold_q;
            if (state_q == c_RACE) begin
                if (bus.frame_tick) begin
                    // A hit coinciding with the tick belongs to the next frame
                    off_hit_d = w_off_pix;
                    fin_hit_d = w_fin_pix;
                    if (off_hit_q && (hold_q == '0)) begin
                        hold_d = c_HOLD;
                    end else if (hold_q != '0) begin
                        hold_d = hold_q - 1'b1;
                    end
                    if (fin_hit_q && !fin_prev_q && (hold_q == '0) && (lap_q < c_LAPS)) begin
                        lap_d = lap_q + 1'b1;
                    end
                    fin_prev_d = fin_hit_q;
                end else begin
                    off_hit_d = off_hit_q | w_off_pix;
                    fin_hit_d = fin_hit_q | w_fin_pix;
                end
            end
            if (w_to_idle) begin
                off_hit_d  = 1'b0;
                fin_hit_d  = 1'b0;
                fin_prev_d = 1'b0;
                lap_d      = '0;
                hold_d     = '0;
            end
        end

        // Per-car state registers
        always_ff @(posedge clk) begin
            if (reset) begin
                off_hit_q  <= 1'b0;
                fin_hit_q  <= 1'b0;
                fin_prev_q <= 1'b0;
                lap_q      <= '0;
                hold_q     <= '0;
            end else begin
                off_hit_q  <= off_hit_d;
                fin_hit_q  <= fin_hit_d;
                fin_prev_q <= fin_prev_d;
                lap_q      <= lap_d;
                hold_q     <= hold_d;
            end
        end

        assign w_lap_full[i]          = (lap_q == c_LAPS);
        assign w_freeze[i]            = (hold_q != '0);
        assign w_lap_count[i*LW +: LW] = lap_q;
    end

    assign bus.start_en        = (state_q == c_IDLE);
    assign bus.game_reset      = (state_q == c_IDLE);
    assign bus.countdown_en    = (state_q == c_COUNTDOWN);
    assign bus.countdown_digit = (state_q == c_COUNTDOWN) ? digit_q : 2'd0;
    assign bus.pause           = (state_q != c_RACE);
    assign bus.finish_en       = (state_q == c_OVER);
    assign bus.winner          = winner_q;
    assign bus.car_freeze      = w_freeze;
    assign bus.lap_count       = w_lap_count;

endmodule
`default_nettype wire

// File: tb/tb_race_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_race_controller
// Description : Directed self-checking bench for race_controller with
//               NUM_CARS=2, LAPS=2, COUNTDOWN_FRAMES=2, CRASH_HOLD_FRAMES=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_race_controller;
    // {start_en, countdown_en, pause, finish_en} for each state
    localparam logic [3:0] c_ST_IDLE   = 4'b1010;
    localparam logic [3:0] c_ST_CD     = 4'b0110;
    localparam logic [3:0] c_ST_RACE   = 4'b0000;
    localparam logic [3:0] c_ST_PAUSED = 4'b0010;
    localparam logic [3:0] c_ST_OVER   = 4'b0011;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    race_controller_if #(.NUM_CARS(2), .LAPS(2)) bus ();

    race_controller #(
        .NUM_CARS(2),
        .LAPS(2),
        .COUNTDOWN_FRAMES(2),
        .CRASH_HOLD_FRAMES(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status();
        return {28'd0, bus.start_en, bus.countdown_en, bus.pause, bus.finish_en};
    endfunction

    task automatic tick();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
    endtask

    task automatic hit(input logic [1:0] cars, input logic road, input logic fin);
        bus.video_on    = 1'b1;
        bus.car_on      = cars;
        bus.road_on     = road;
        bus.finish_line = fin;
        step();
        bus.video_on    = 1'b0;
        bus.car_on      = 2'b00;
        bus.road_on     = 1'b1;
        bus.finish_line = 1'b0;
    endtask

    task automatic press_enter();
        bus.enter_key = 1'b1;
        step();
        bus.enter_key = 1'b0;
    endtask

    task automatic press_pause();
        bus.pause_key = 1'b1;
        step();
        bus.pause_key = 1'b0;
    endtask

    task automatic go_race();
        press_enter();
        step();
        for (int k = 0; k < 6; k++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors         = 0;
        miscompares     = 0;
        reset           = 1'b1;
        bus.frame_tick  = 1'b0;
        bus.video_on    = 1'b0;
        bus.road_on     = 1'b1;
        bus.finish_line = 1'b0;
        bus.car_on      = 2'b00;
        bus.enter_key   = 1'b1;
        bus.pause_key   = 1'b0;
        step();
        step();
        reset = 1'b0;

        // ---- 1: reset state, held enter ignored, countdown sequence
        chk("rst_status", status(), c_ST_IDLE);
        chk("rst_game_reset", bus.game_reset, 1);
        chk("rst_lap", bus.lap_count, 0);
        chk("rst_freeze", bus.car_freeze, 0);
        chk("rst_winner", bus.winner, 0);
        chk("rst_digit", bus.countdown_digit, 0);
        for (int k = 0; k < 10; k++) step();
        chk("held_enter_idle", status(), c_ST_IDLE);
        bus.enter_key = 1'b0;
        step();
        press_enter();
        chk("cd_entry", status(), c_ST_CD);
        begin
            logic [1:0] exp_digit [6] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1};
            for (int k = 0; k < 6; k++) begin
                chk("cd_digit", bus.countdown_digit, exp_digit[k]);
                tick();
            end
        end
        chk("race_entry", status(), c_ST_RACE);
        chk("race_digit", bus.countdown_digit, 0);

        // ---- 2: car 0 crosses in frames 1, 2, 5
        hit(2'b01, 1'b1, 1'b1); tick();
        chk("lap0_f1", bus.lap_count, 4'b0001);
        hit(2'b01, 1'b1, 1'b1); tick();
        chk("lap0_f2", bus.lap_count, 4'b0001);
        tick(); tick();
        chk("lap0_f4", bus.lap_count, 4'b0001);
        hit(2'b01, 1'b1, 1'b1); tick();
        chk("lap0_f5", bus.lap_count, 4'b0010);
        chk("still_race", status(), c_ST_RACE);
        step();
        chk("over_entry", status(), c_ST_OVER);
        chk("winner_car0", bus.winner, 0);
        press_enter();
        chk("over_to_idle", status(), c_ST_IDLE);
        chk("idle_lap_clear", bus.lap_count, 0);
        step();

        // ---- 3: car 1 crash penalty
        go_race();
        hit(2'b10, 1'b0, 1'b0); tick();
        chk("crash_t1", bus.car_freeze, 2'b10);
        hit(2'b10, 1'b0, 1'b0); tick();
        chk("crash_t2", bus.car_freeze, 2'b10);
        hit(2'b10, 1'b1, 1'b1); tick();
        chk("crash_t3", bus.car_freeze, 2'b10);
        chk("crash_no_lap", bus.lap_count, 0);
        tick();
        chk("crash_t4_release", bus.car_freeze, 2'b00);
        hit(2'b10, 1'b1, 1'b1); tick();
        chk("lap1_after_hold", bus.lap_count, 4'b0100);

        // ---- 5: pause freezes counters, resume, then abort
        hit(2'b01, 1'b0, 1'b0); tick();
        chk("crash0", bus.car_freeze, 2'b01);
        press_pause();
        chk("paused", status(), c_ST_PAUSED);
        hit(2'b11, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) tick();
        chk("paused_freeze", bus.car_freeze, 2'b01);
        chk("paused_lap", bus.lap_count, 4'b0100);
        chk("paused_still", status(), c_ST_PAUSED);
        press_pause();
        chk("resumed", status(), c_ST_RACE);
        tick();
        chk("resume_freeze", bus.car_freeze, 2'b01);
        chk("resume_lap", bus.lap_count, 4'b0100);
        press_pause();
        chk("paused2", status(), c_ST_PAUSED);
        press_enter();
        chk("abort_idle", status(), c_ST_IDLE);
        chk("abort_lap", bus.lap_count, 0);
        chk("abort_freeze", bus.car_freeze, 0);
        step();

        // ---- 4: simultaneous finish, with a pause press on the win cycle
        go_race();
        hit(2'b11, 1'b1, 1'b1); tick();
        tick();
        hit(2'b11, 1'b1, 1'b1); tick();
        chk("tie_laps", bus.lap_count, 4'b1010);
        press_pause();
        chk("tie_over_vs_pause", status(), c_ST_OVER);
        chk("tie_winner", bus.winner, 0);
        press_enter();
        step();

        // car 1 alone wins
        go_race();
        hit(2'b10, 1'b1, 1'b1); tick();
        tick();
        hit(2'b10, 1'b1, 1'b1); tick();
        step();
        chk("car1_over", status(), c_ST_OVER);
        chk("car1_winner", bus.winner, 1);
        chk("car1_lap_sat", bus.lap_count, 4'b1000);
        press_enter();
        step();

        // ---- 6: reset mid-countdown
        press_enter();
        tick(); tick();
        chk("mid_cd_digit", bus.countdown_digit, 2);
        reset = 1'b1;
        step();
        chk("reset_cd_status", status(), c_ST_IDLE);
        chk("reset_cd_digit", bus.countdown_digit, 0);
        chk("reset_cd_lap", bus.lap_count, 0);
        reset = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
